// File: rtl/aclint_memory.sv
// aclint_memory: memory-mapped ACLINT slave on the core peripheral bus.
// It owns the msip, mtimecmp and mtime registers and the setssip doorbell.
// It feeds MIP.MSIP, MIP.MTIP, the SSIP set request and the TIME CSR to the CSR unit.
//
// Ports:
//   clk, rst       - core clock, synchronous active-high reset
//   bus_valid      - request valid; bus_ready is always 1, so every valid request is accepted
//   bus_addr       - absolute, 8-byte aligned byte address
//   bus_wen        - 1 = write, 0 = read
//   bus_wdata      - write data
//   bus_wmask      - write byte enables
//   bus_rvalid     - response strobe, one cycle after acceptance
//   bus_rdata      - registered read data (0 for write responses)
//   msip           - machine software interrupt pending
//   mtip           - machine timer interrupt pending (mtime >= mtimecmp)
//   setssip        - one-cycle pulse requesting SIP.SSIP set
//   mtime          - current mtime value for the TIME CSR
module aclint_memory #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_valid,
  output logic                    bus_ready,
  input  logic [63:0]             bus_addr,
  input  logic                    bus_wen,
  input  logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH/8-1:0] bus_wmask,
  output logic                    bus_rvalid,
  output logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    msip,
  output logic                    mtip,
  output logic                    setssip,
  output logic [63:0]             mtime
);

  localparam logic [63:0] MMAP_ACLINT_BEGIN = 64'h0000_0000_0200_0000;

  // Word offsets: byte offset bits [15:3]
  localparam logic [12:0] OFF_MSIP     = 13'h0000;  // 0x0000
  localparam logic [12:0] OFF_MTIMECMP = 13'h0800;  // 0x4000
  localparam logic [12:0] OFF_MTIME    = 13'h0fff;  // 0x7ff8
  localparam logic [12:0] OFF_SETSSIP  = 13'h1000;  // 0x8000

  localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Byte-granular merge of new data into an existing 64-bit value
  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = mask[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0]      mtime_r;
  logic [63:0]      mtimecmp_r;
  logic             msip_r;
  logic [DIV_W-1:0] div_r;
  logic             rvalid_r;
  logic [63:0]      rdata_r;
  logic             setssip_r;

  logic [63:0] offset_s;
  logic [12:0] word_s;
  logic        in_window_s;
  logic        accept_s;
  logic        wr_s;
  logic        wr_msip_s;
  logic        wr_mtimecmp_s;
  logic        wr_mtime_s;
  logic        wr_setssip_s;
  logic        tick_s;
  logic [63:0] rdata_s;
  logic [63:0] mtime_next_s;
  logic        unused_addr_s;

  assign offset_s      = bus_addr - MMAP_ACLINT_BEGIN;
  // Addresses below the base wrap to huge offsets, so the upper-bits test covers both ends
  assign in_window_s   = (offset_s[63:16] == 48'h0);
  assign word_s        = offset_s[15:3];
  assign unused_addr_s = ^offset_s[2:0];

  assign bus_ready     = 1'b1;
  assign accept_s      = bus_valid && bus_ready;
  assign wr_s          = accept_s && bus_wen && in_window_s;
  assign wr_msip_s     = wr_s && (word_s == OFF_MSIP);
  assign wr_mtimecmp_s = wr_s && (word_s == OFF_MTIMECMP);
  assign wr_mtime_s    = wr_s && (word_s == OFF_MTIME);
  assign wr_setssip_s  = wr_s && (word_s == OFF_SETSSIP);

  assign tick_s = (div_r == DIV_LAST);

  // Read mux: register values before any update in this cycle
  always_comb begin
    rdata_s = 64'h0;
    if (in_window_s) begin
      case (word_s)
        OFF_MSIP:     rdata_s = {63'h0, msip_r};
        OFF_MTIMECMP: rdata_s = mtimecmp_r;
        OFF_MTIME:    rdata_s = mtime_r;
        default:      rdata_s = 64'h0;
      endcase
    end else begin
      rdata_s = 64'h0;
    end
  end

  // Next mtime: a bus write beats the tick increment and merges into the pre-increment value
  always_comb begin
    mtime_next_s = mtime_r;
    if (wr_mtime_s) begin
      mtime_next_s = byte_merge(mtime_r, bus_wdata, bus_wmask);
    end else if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
  end

  // Tick divider: free-running, unaffected by mtime writes
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Timer and software-interrupt registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_r    <= 64'h0;
      mtimecmp_r <= 64'hffff_ffff_ffff_ffff;
      msip_r     <= 1'b0;
    end else begin
      mtime_r <= mtime_next_s;
      if (wr_mtimecmp_s) begin
        mtimecmp_r <= byte_merge(mtimecmp_r, bus_wdata, bus_wmask);
      end
      if (wr_msip_s && bus_wmask[0]) begin
        msip_r <= bus_wdata[0];
      end
    end
  end

  // Bus response and setssip doorbell pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r  <= 1'b0;
      rdata_r   <= 64'h0;
      setssip_r <= 1'b0;
    end else begin
      rvalid_r  <= accept_s;
      rdata_r   <= (accept_s && !bus_wen) ? rdata_s : 64'h0;
      setssip_r <= wr_setssip_s && bus_wmask[0] && bus_wdata[0];
    end
  end

  assign bus_rvalid = rvalid_r;
  assign bus_rdata  = rdata_r;
  assign setssip    = setssip_r;
  assign msip       = msip_r;
  assign mtime      = mtime_r;
  assign mtip       = (mtime_r >= mtimecmp_r);

endmodule

// File: tb/tb_aclint_memory.sv
// Bench for aclint_memory: two instances (TICK_DIV = 1 and 4) share one bus stimulus
// and are compared against a register-level reference model after every clock.
module tb_aclint_memory;

  localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP   = BASE + 64'h0000;
  localparam logic [63:0] A_CMP    = BASE + 64'h4000;
  localparam logic [63:0] A_MTIME  = BASE + 64'h7ff8;
  localparam logic [63:0] A_SSIP   = BASE + 64'h8000;
  localparam logic [63:0] A_UNMAP  = BASE + 64'h1000;
  localparam logic [63:0] ALL_ONES = 64'hffff_ffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;

  logic        o_ready[2];
  logic        o_rvalid[2];
  logic [63:0] o_rdata[2];
  logic        o_msip[2];
  logic        o_mtip[2];
  logic        o_ss[2];
  logic [63:0] o_mtime[2];

  // Reference model state
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  int unsigned m_cyc;
  int unsigned div_of[2] = '{1, 4};
  logic        e_rvalid[2];
  logic [63:0] e_rdata[2];
  logic        e_ss[2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aclint_memory #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(o_ready[0]),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(o_rvalid[0]), .bus_rdata(o_rdata[0]), .msip(o_msip[0]), .mtip(o_mtip[0]),
    .setssip(o_ss[0]), .mtime(o_mtime[0])
  );

  aclint_memory #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(o_ready[1]),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(o_rvalid[1]), .bus_rdata(o_rdata[1]), .msip(o_msip[1]), .mtip(o_mtip[1]),
    .setssip(o_ss[1]), .mtime(o_mtime[1])
  );

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One bus cycle: drive, advance the model, clock, then compare everything
  task automatic step(input logic r, input logic v, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] m);
    logic [63:0] al;
    logic [63:0] rd;
    logic        tick;
    rst = r; bus_valid = v; bus_wen = w; bus_addr = a; bus_wdata = d; bus_wmask = m;
    al = {a[63:3], 3'b000};
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        e_rvalid[k] = 1'b0; e_rdata[k] = 64'h0; e_ss[k] = 1'b0;
        m_mtime[k] = 64'h0; m_cmp[k] = ALL_ONES; m_msip[k] = 1'b0;
      end else begin
        if (al == A_MSIP) rd = {63'h0, m_msip[k]};
        else if (al == A_CMP) rd = m_cmp[k];
        else if (al == A_MTIME) rd = m_mtime[k];
        else rd = 64'h0;
        e_rvalid[k] = v;
        e_rdata[k]  = (v && !w) ? rd : 64'h0;
        e_ss[k]     = v && w && (al == A_SSIP) && m[0] && d[0];
        tick = ((m_cyc % div_of[k]) == div_of[k] - 1);
        if (v && w && al == A_MTIME) m_mtime[k] = merge(m_mtime[k], d, m);
        else if (tick) m_mtime[k] = m_mtime[k] + 64'd1;
        if (v && w && al == A_CMP) m_cmp[k] = merge(m_cmp[k], d, m);
        if (v && w && al == A_MSIP && m[0]) m_msip[k] = d[0];
      end
    end
    m_cyc = r ? 0 : m_cyc + 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("ready",   k, {63'h0, o_ready[k]},  64'd1);
      chk("rvalid",  k, {63'h0, o_rvalid[k]}, {63'h0, e_rvalid[k]});
      chk("rdata",   k, o_rdata[k],           e_rdata[k]);
      chk("mtime",   k, o_mtime[k],           m_mtime[k]);
      chk("mtip",    k, {63'h0, o_mtip[k]},   {63'h0, (m_mtime[k] >= m_cmp[k])});
      chk("msip",    k, {63'h0, o_msip[k]},   {63'h0, m_msip[k]});
      chk("setssip", k, {63'h0, o_ss[k]},     {63'h0, e_ss[k]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    step(1'b0, 1'b1, 1'b1, a, d, m);
  endtask

  task automatic rd(input logic [63:0] a);
    step(1'b0, 1'b1, 1'b0, a, 64'h0, 8'h00);
  endtask

  initial begin
    logic [63:0] addrs[7];
    logic [63:0] ra;
    logic [63:0] rdv;
    m_cyc = 0;
    addrs = '{A_MSIP, A_CMP, A_MTIME, A_SSIP, A_UNMAP,
              64'h0000_0000_0100_0000, 64'h0000_0000_0201_0000};

    // Reset, then idle
    step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    idle(5);
    chk("mtime_after_5", 0, o_mtime[0], 64'd5);
    chk("mtip_after_5",  0, {63'h0, o_mtip[0]}, 64'd0);

    // Timer compare: rise at 10, fall after raising compare
    wr(A_CMP, 64'd10, 8'hff);
    idle(12);
    chk("mtip_reached", 0, {63'h0, o_mtip[0]}, 64'd1);
    wr(A_CMP, ALL_ONES, 8'hff);
    chk("mtip_cleared", 0, {63'h0, o_mtip[0]}, 64'd0);
    idle(2);

    // Partial MTIME write during a tick replaces only the low word, no increment
    wr(A_MTIME, 64'h0000_0005_0000_0000, 8'hff);
    wr(A_MTIME, 64'h0000_0001_ffff_fff0, 8'h0f);
    rd(A_MTIME);
    chk("mtime_partial", 0, o_rdata[0], 64'h0000_0005_ffff_fff0);

    // MSIP
    wr(A_MSIP, 64'd1, 8'hff);
    rd(A_MSIP);
    chk("msip_read", 0, o_rdata[0], 64'd1);
    wr(A_MSIP, 64'd2, 8'hff);
    rd(A_MSIP);

    // SETSSIP doorbell and unmapped read
    wr(A_SSIP, 64'd1, 8'h01);
    chk("setssip_pulse", 0, {63'h0, o_ss[0]}, 64'd1);
    idle(1);
    rd(A_SSIP);
    wr(A_SSIP, 64'd0, 8'hff);
    rd(A_UNMAP);

    // mtime wrap
    wr(A_MTIME, ALL_ONES, 8'hff);
    idle(3);

    // Reset with a response pending, TICK_DIV=4 increment cadence
    rd(A_MTIME);
    step(1'b1, 1'b1, 1'b0, A_MTIME, 64'h0, 8'h00);
    idle(8);
    chk("div4_mtime", 1, o_mtime[1], 64'd2);
    rd(A_CMP);
    chk("cmp_reset", 1, o_rdata[1], ALL_ONES);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = addrs[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 0) rdv = m_mtime[$urandom_range(0, 1)] + 64'($urandom_range(0, 8));
      else rdv = {$urandom, $urandom};
      if ($urandom_range(0, 60) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, ra, 64'h0, 8'h00);
      else
        step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rdv,
             8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
